// File: rtl/ps2_button_mapper_if.sv
// ps2_button_mapper_if: PS/2, key-table, joystick and coin signals between hps_io side and the mapper
interface ps2_button_mapper_if #(
  parameter int NUM_BTN = 10,
  parameter int IDX_W   = 4
);
  logic [10:0]        ps2_key;
  logic               map_wr;
  logic [IDX_W-1:0]   map_idx;
  logic [8:0]         map_code;
  logic               map_ext_any;
  logic [NUM_BTN-1:0] joy_in;
  logic               coin_req;
  logic [NUM_BTN-1:0] btn_out;
  logic               coin_out;
  logic               key_event;
  modport master (
    output ps2_key, map_wr, map_idx, map_code, map_ext_any, joy_in, coin_req,
    input  btn_out, coin_out, key_event
  );
  modport slave (
    input  ps2_key, map_wr, map_idx, map_code, map_ext_any, joy_in, coin_req,
    output btn_out, coin_out, key_event
  );
endinterface

// File: rtl/ps2_button_mapper.sv
// ps2_button_mapper: runtime-loadable PS/2 key table merged with joystick, plus timed coin pulse
module ps2_button_mapper #(
  parameter int NUM_BTN = 10,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 24,
  parameter logic [CNT_W-1:0] COIN_PULSE = 24'd800000,
  parameter logic [CNT_W-1:0] COIN_GAP   = 24'd800000
) (
  input logic clk_sys,
  input logic reset_n,
  ps2_button_mapper_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} state_t;
  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               strobe_d, coin_req_d, evt, rise;
  logic [8:0]         code [NUM_BTN];
  logic [NUM_BTN-1:0] ext_any, valid, key_state, hit, wr_hit;
  assign evt  = bus.ps2_key[10] != strobe_d;
  assign rise = bus.coin_req & ~coin_req_d;
  always_comb begin
    wr_hit = '0;
    hit    = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      wr_hit[i] = bus.map_wr && bus.map_idx == IDX_W'(i);
      hit[i]    = valid[i] && code[i][7:0] == bus.ps2_key[7:0] &&
                  (ext_any[i] || code[i][8] == bus.ps2_key[8]);
    end
  end
  always_ff @(posedge clk_sys)
    for (int i = 0; i < NUM_BTN; i++)
      if (wr_hit[i]) {ext_any[i], code[i]} <= {bus.map_ext_any, bus.map_code};
  // a write to an entry takes priority over a same-cycle event on it
  always_ff @(posedge clk_sys) begin
    strobe_d <= bus.ps2_key[10];
    if (!reset_n) begin
      valid         <= '0;
      key_state     <= '0;
      bus.btn_out   <= '0;
      bus.key_event <= 1'b0;
    end else begin
      bus.key_event <= evt;
      bus.btn_out   <= key_state | bus.joy_in;
      for (int i = 0; i < NUM_BTN; i++)
        if (wr_hit[i]) begin
          valid[i]     <= 1'b1;
          key_state[i] <= 1'b0;
        end else if (evt && hit[i]) key_state[i] <= bus.ps2_key[9];
    end
  end
  always_ff @(posedge clk_sys) begin
    coin_req_d <= bus.coin_req;
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE:    if (rise) begin
                 nxt     = PULSE;
                 cnt_nxt = COIN_PULSE - CNT_W'(1);
               end
      PULSE:   if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
               else begin
                 nxt     = HOLDOFF;
                 cnt_nxt = COIN_GAP - CNT_W'(1);
               end
      HOLDOFF: if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
               else nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb bus.coin_out = state == PULSE;
endmodule

// File: tb/tb_ps2_button_mapper.sv
// tb_ps2_button_mapper: scoreboard bench; a per-edge reference model queues expected outputs, a monitor checks them
module tb_ps2_button_mapper;
  localparam int NB = 10, IW = 4, CW = 24, PULSE = 4, GAP = 3;
  typedef struct {
    logic [NB-1:0] btn;
    logic          coin;
    logic          ke;
  } exp_t;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  ps2_button_mapper_if #(.NUM_BTN(NB), .IDX_W(IW)) bus ();
  ps2_button_mapper #(.NUM_BTN(NB), .IDX_W(IW), .CNT_W(CW),
    .COIN_PULSE(24'(PULSE)), .COIN_GAP(24'(GAP))) dut (
    .clk_sys(clk), .reset_n(rst_n), .bus(bus.slave));
  exp_t q[$];
  int checks = 0, fails = 0;
  logic [8:0]    m_code [NB];
  bit   [NB-1:0] m_ext, m_valid, m_ks;
  bit            p_strobe, p_req, started;
  int            start_cyc, cyc = 0;
  logic [8:0]    pool [6] = '{9'h075, 9'h175, 9'h01D, 9'h11D, 9'h023, 9'h05A};
  task automatic chk(string n, logic [31:0] a, logic [31:0] r);
    checks++;
    if (a !== r) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", n, $time, a, r);
    end
  endtask
  // behavioural model: table of entries, key states, and coin pulse timing from the start time of the last pulse
  task automatic model_edge();
    exp_t e;
    bit evt, rise;
    if (!rst_n) begin
      e = '{btn: '0, coin: 1'b0, ke: 1'b0};
      m_valid = '0;
      m_ks = '0;
      started = 0;
    end else begin
      evt = bus.ps2_key[10] != p_strobe;
      e.ke = evt;
      e.btn = m_ks | bus.joy_in;
      for (int i = 0; i < NB; i++)
        if (bus.map_wr && int'(bus.map_idx) == i) begin
          m_code[i] = bus.map_code;
          m_ext[i] = bus.map_ext_any;
          m_valid[i] = 1;
          m_ks[i] = 0;
        end else if (evt && m_valid[i] && m_code[i][7:0] == bus.ps2_key[7:0] &&
                     (m_ext[i] || m_code[i][8] == bus.ps2_key[8]))
          m_ks[i] = bus.ps2_key[9];
      rise = bus.coin_req && !p_req;
      if (rise && (!started || cyc - start_cyc >= PULSE + GAP + 1)) begin
        started = 1;
        start_cyc = cyc;
      end
      e.coin = started && (cyc - start_cyc < PULSE);
    end
    p_strobe = bus.ps2_key[10];
    p_req = bus.coin_req;
    cyc++;
    q.push_back(e);
  endtask
  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("btn_out", 32'(bus.btn_out), 32'(e.btn));
      chk("coin_out", 32'(bus.coin_out), 32'(e.coin));
      chk("key_event", 32'(bus.key_event), 32'(e.ke));
    end
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask
  task automatic idle(int n);
    repeat (n) step();
  endtask
  task automatic wr(int idx, logic [8:0] c, bit ext);
    bus.map_wr = 1;
    bus.map_idx = IW'(idx);
    bus.map_code = c;
    bus.map_ext_any = ext;
    step();
    bus.map_wr = 0;
  endtask
  task automatic key(bit pressed, logic [8:0] c);
    bus.ps2_key = {~bus.ps2_key[10], pressed, c};
    step();
  endtask
  initial begin
    rst_n = 0;
    bus.ps2_key = '0;
    bus.map_wr = 0;
    bus.map_idx = '0;
    bus.map_code = '0;
    bus.map_ext_any = 0;
    bus.joy_in = '0;
    bus.coin_req = 0;
    idle(3);
    rst_n = 1;
    idle(2);
    wr(3, 9'h075, 1);
    key(1, 9'h175);
    idle(3);
    key(0, 9'h175);
    idle(3);
    wr(5, 9'h01D, 0);
    key(1, 9'h11D);
    idle(2);
    key(1, 9'h01D);
    idle(2);
    wr(6, 9'h023, 0);
    wr(7, 9'h023, 0);
    key(1, 9'h023);
    idle(2);
    key(1, 9'h075);
    idle(2);
    bus.map_wr = 1;
    bus.map_idx = 4'd3;
    bus.map_code = 9'h05A;
    bus.map_ext_any = 0;
    key(0, 9'h075);
    bus.map_wr = 0;
    idle(2);
    key(1, 9'h075);
    idle(2);
    key(1, 9'h05A);
    idle(2);
    wr(12, 9'h075, 1);
    key(0, 9'h075);
    idle(2);
    bus.joy_in = 10'd1;
    idle(2);
    wr(0, 9'h016, 0);
    key(1, 9'h016);
    bus.joy_in = '0;
    idle(3);
    bus.coin_req = 1;
    idle(20);
    bus.coin_req = 0;
    idle(2);
    bus.coin_req = 1;
    step();
    bus.coin_req = 0;
    idle(4);
    bus.coin_req = 1;
    idle(3);
    bus.coin_req = 0;
    idle(2);
    bus.coin_req = 1;
    idle(6);
    bus.coin_req = 0;
    idle(3);
    bus.coin_req = 1;
    idle(2);
    rst_n = 0;
    bus.ps2_key[10] = ~bus.ps2_key[10];
    idle(2);
    rst_n = 1;
    idle(12);
    repeat (1500) begin
      bus.map_wr = $urandom_range(9) == 0;
      bus.map_idx = IW'($urandom_range(15));
      bus.map_code = pool[$urandom_range(5)];
      bus.map_ext_any = 1'($urandom);
      if ($urandom_range(9) < 3)
        bus.ps2_key = {~bus.ps2_key[10], 1'($urandom), pool[$urandom_range(5)]};
      if ($urandom_range(9) == 0) bus.joy_in = NB'($urandom);
      if ($urandom_range(19) < 3) bus.coin_req = ~bus.coin_req;
      rst_n = $urandom_range(99) != 0;
      step();
    end
    rst_n = 1;
    bus.map_wr = 0;
    idle(2);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ps2_button_mapper.md
Name: ps2_button_mapper

Overview:
- Parametrised keyboard/joystick-to-button front end for arcade cores.
- Replaces hard-coded per-core PS/2 case decoding with a runtime-loadable key table of NUM_BTN entries, plus optional extended-prefix wildcard per entry.
- Merges the decoded keys with joystick bits and generates a timed coin pulse with hold-off from a level request.
- Sits between hps_io (ps2_key, joystick) and the arcade core's control inputs.

Parameters:
NUM_BTN, 10, number of mapped buttons / table entries (1..32)
IDX_W, 4, width of map_idx; must satisfy 2**IDX_W >= NUM_BTN
CNT_W, 24, coin timer width
COIN_PULSE, 24'd800000, coin_out high time in clk_sys cycles (>=1)
COIN_GAP, 24'd800000, hold-off after pulse in clk_sys cycles (>=1)

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  synchronous reset, active low
ps2_key  in  11  [10] toggle strobe, [9] pressed, [8] extended flag, [7:0] scancode
map_wr  in  1  table write strobe, one entry per cycle
map_idx  in  IDX_W  table entry index
map_code  in  9  {extended, scancode} for entry
map_ext_any  in  1  1 = entry ignores bit 8 when matching
joy_in  in  NUM_BTN  joystick bits, already ordered to button index
coin_req  in  1  level coin request (e.g. start1|start2)
btn_out  out  NUM_BTN  registered merged button state
coin_out  out  1  registered coin pulse
key_event  out  1  one-cycle pulse per detected PS/2 strobe toggle

Behaviour:
- Reset (reset_n=0 at edge): btn_out=0, coin_out=0, key_event=0, key_state=0, all entry valid bits=0, coin FSM=IDLE, counter=0; strobe_d <= ps2_key[10] and coin_req_d <= coin_req, so neither a pending toggle nor a held request fires on release. Reset mid-pulse aborts the pulse; coin_out goes 0 at the reset edge.
- Table write: map_wr=1 and map_idx<NUM_BTN -> entry[map_idx] <= {map_ext_any, map_code}, valid<=1, key_state[map_idx]<=0. map_idx>=NUM_BTN ignored. No read port.
- Event detect: evt = (ps2_key[10] != strobe_d); strobe_d <= ps2_key[10] each cycle; key_event <= evt.
- Match: entry i matches when valid_i and code[7:0]==ps2_key[7:0] and (ext_any_i or code[8]==ps2_key[8]). On evt, every matching entry sets key_state[i] <= ps2_key[9]. Non-matching entries hold. Duplicate codes across entries are legal; all matching entries update.
- Write/event collision on same index and cycle: write wins; key_state bit cleared; the new code is not applied to that event.
- Merge: btn_out <= key_state | joy_in every cycle. Latency: strobe toggle before edge E0 -> key_state at E0 -> btn_out at E1. joy_in -> btn_out at next edge.
- Coin FSM, rise = coin_req & ~coin_req_d, coin_req_d updated every cycle:
  - IDLE: on rise -> PULSE, cnt<=COIN_PULSE-1, coin_out<=1.
  - PULSE: cnt!=0 -> cnt-1; cnt==0 -> HOLDOFF, coin_out<=0, cnt<=COIN_GAP-1.
  - HOLDOFF: cnt!=0 -> cnt-1; cnt==0 -> IDLE.
  - Rises during PULSE/HOLDOFF are dropped, not queued. A level held through HOLDOFF does not retrigger; a new rise is required.
  - coin_out is high for exactly COIN_PULSE cycles. Minimum spacing between pulse starts is COIN_PULSE+COIN_GAP+1 cycles.
- Counter is unsigned CNT_W bits; no wrap occurs in legal use.

Test Plan:
- Bench parameters: NUM_BTN=10, COIN_PULSE=4, COIN_GAP=3.
- Reset, then load entry 3 = 9'h075 with ext_any=1; toggle ps2_key with {pressed=1, 9'h175} -> key_event pulse 1 cycle; btn_out[3]=1 two edges after toggle. Repeat with pressed=0 -> btn_out[3]=0.
- Entry 5 = 9'h01D with ext_any=0; send 9'h11D pressed -> btn_out[5] stays 0; send 9'h01D -> btn_out[5]=1. Entries 6 and 7 both 9'h023; press 23 -> btn_out[7:6]=2'b11.
- Key pressed (btn_out[3]=1), then map_wr idx 3 with new code in the same cycle as a matching release toggle -> btn_out[3]=0; entry holds new code. map_idx=12 write -> no change.
- joy_in[0]=1 with no keys -> btn_out[0]=1 one edge later; key press on same bit, then joy release -> btn_out[0] stays 1.
- coin_req rises and is held 20 cycles -> coin_out=1 for exactly 4 cycles, single pulse. Drop coin_req, re-raise during HOLDOFF -> no pulse. Re-raise after IDLE -> second pulse; pulse starts at least 8 cycles apart.
- reset_n=0 during PULSE with coin_req and strobe held/toggled -> coin_out=0, btn_out=0, table invalid. After release, no pulse and no key_event until new edges.
